tea_job_scheduler: RTL and testbench

Sequencing and arbitration controller placed in front of one TEA encryption core. It accepts encryption jobs from `N_REQ` requesters over valid/ready handshakes and grants them round-robin. It launches each job on the shared core, waits for completion with a watchdog, and returns the ciphertext tagged with the requester ID. It owns the core's `start` and `reset_n` inputs and holds the core's plaintext and key operands stable for the whole job.

---
 rtl/tea_pkg.sv | 25 ++
 rtl/tea_rr_arbiter.sv | 43 ++++
 rtl/tea_job_scheduler.sv | 152 +++++++++++++++
 tb/tb_tea_job_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : tea_pkg                                                    |
// | Purpose : Shared types and width constants for the TEA job           |
// |           scheduler and its round-robin arbiter.                     |
// | Contents: tea_sched_state_t - scheduler FSM state encoding           |
// |           TEA_BLK_W / TEA_KEY_W / TEA_HALF_W - TEA operand widths    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package tea_pkg;

  localparam int TEA_BLK_W  = 64;   // plaintext / ciphertext block
  localparam int TEA_KEY_W  = 128;  // key
  localparam int TEA_HALF_W = 32;   // one half-block word

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    BUSY   = 3'd2,
    ABORT  = 3'd3,
    RESP   = 3'd4
  } tea_sched_state_t;

endpackage : tea_pkg
`default_nettype wire

// File: rtl/tea_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tea_rr_arbiter                                             |
// | Purpose : Combinational round-robin grant. The search starts at      |
// |           (last_grant+1) mod N_REQ and wraps upward.                 |
// | Ports   : req_valid  in  N_REQ  - per-requester request              |
// |           last_grant in  IDW    - most recently served requester     |
// |           grant      out N_REQ  - one-hot grant (zero if none)       |
// |           grant_idx  out IDW    - index of the granted requester     |
// |           any        out 1      - at least one request present      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tea_rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDW   = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             any
);

  always_comb begin : p_grant
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Offset 1 first so the previous winner has the lowest priority;
    // offset N_REQ comes back to last_grant itself as the final choice.
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last_grant) + off) % N_REQ;
      if (!any && req_valid[idx]) begin
        any        = 1'b1;
        grant_idx  = IDW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule : tea_rr_arbiter
`default_nettype wire

// File: rtl/tea_job_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tea_job_scheduler                                          |
// | Purpose : Accepts TEA jobs from N_REQ requesters (round-robin),      |
// |           launches each on one shared core, watches it with a        |
// |           timeout, and returns the ciphertext tagged with the ID.    |
// | Ports   : clk, reset (sync, active-high)                             |
// |           req_valid/req_ready/req_plain/req_key - requester side     |
// |           rsp_valid/rsp_ready/rsp_id/rsp_cipher/rsp_err - response   |
// |           core_start/core_reset_n/core_plain/core_key - core control |
// |           core_done/core_cipher - core result                        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tea_job_scheduler
  import tea_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*TEA_BLK_W-1:0] req_plain,
  input  logic [N_REQ*TEA_KEY_W-1:0] req_key,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [TEA_BLK_W-1:0]       rsp_cipher,
  output logic                       rsp_err,
  output logic                       core_start,
  output logic                       core_reset_n,
  output logic [TEA_BLK_W-1:0]       core_plain,
  output logic [TEA_KEY_W-1:0]       core_key,
  input  logic                       core_done,
  input  logic [TEA_BLK_W-1:0]       core_cipher
);

  localparam int                CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDW-1:0]    LAST_INIT = IDW'(N_REQ - 1);

  tea_sched_state_t     state, state_next;
  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       job_id;
  logic [IDW-1:0]       grant_idx;
  logic [N_REQ-1:0]     grant_oh;
  logic                 grant_any;
  logic [CNT_W-1:0]     cnt;
  logic [TEA_BLK_W-1:0] job_plain;
  logic [TEA_KEY_W-1:0] job_key;
  logic                 accept;
  logic                 done_ok;
  logic                 timed_out;
  logic                 rsp_fire;

  tea_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant_oh),
    .grant_idx  (grant_idx),
    .any        (grant_any)
  );

  // Operands come straight from the job registers, which only load in
  // IDLE, so they cannot move while the core is working.
  assign core_plain = job_plain;
  assign core_key   = job_key;
  assign rsp_id     = job_id;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    done_ok      = 1'b0;
    timed_out    = 1'b0;
    rsp_fire     = 1'b0;
    req_ready    = '0;
    core_start   = 1'b0;
    rsp_valid    = 1'b0;
    core_reset_n = !reset;
    case (state)
      IDLE: begin
        if (!reset) begin
          req_ready = grant_oh;
          accept    = grant_any;
        end
        if (accept) state_next = LAUNCH;
      end
      LAUNCH: begin
        core_start = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        // cnt==0 is the first BUSY cycle: a done seen here may be the
        // previous job's level still high, so it is not trusted.
        if (core_done && (cnt != '0)) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          timed_out  = 1'b1;
          state_next = ABORT;
        end
      end
      ABORT: begin
        core_reset_n = 1'b0;
        state_next   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_fire  = rsp_ready;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= LAST_INIT;
      job_id     <= '0;
      job_plain  <= '0;
      job_key    <= '0;
      cnt        <= '0;
      rsp_cipher <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        job_id    <= grant_idx;
        job_plain <= req_plain[int'(grant_idx)*TEA_BLK_W +: TEA_BLK_W];
        job_key   <= req_key[int'(grant_idx)*TEA_KEY_W +: TEA_KEY_W];
      end
      if (state == LAUNCH)    cnt <= '0;
      else if (state == BUSY) cnt <= cnt + 1'b1;
      if (done_ok) begin
        rsp_cipher <= core_cipher;
        rsp_err    <= 1'b0;
      end else if (timed_out) begin
        rsp_cipher <= '0;
        rsp_err    <= 1'b1;
      end
      if (rsp_fire) last_grant <= job_id;
    end
  end

endmodule : tea_job_scheduler
`default_nettype wire

// File: tb/tb_tea_job_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_tea_job_scheduler                                       |
// | Purpose : Self-checking bench for tea_job_scheduler with a           |
// |           behavioural TEA core (configurable latency, pulse or       |
// |           level done, never-done).                                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_tea_job_scheduler;

  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [127:0]   req_plain;
  logic [255:0]   req_key;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [0:0]     rsp_id;
  logic [63:0]    rsp_cipher;
  logic           rsp_err;
  logic           core_start;
  logic           core_reset_n;
  logic [63:0]    core_plain;
  logic [127:0]   core_key;
  logic           core_done;
  logic [63:0]    core_cipher;

  int n_vec = 0;
  int n_err = 0;

  // behavioural core controls
  int lat        = 0;   // start-to-done latency, 0 = never done
  bit level_mode = 1'b0;
  int cdown      = 0;
  int clr        = 0;

  always #5 clk = ~clk;

  tea_job_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_plain    (req_plain),
    .req_key      (req_key),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_cipher   (rsp_cipher),
    .rsp_err      (rsp_err),
    .core_start   (core_start),
    .core_reset_n (core_reset_n),
    .core_plain   (core_plain),
    .core_key     (core_key),
    .core_done    (core_done),
    .core_cipher  (core_cipher)
  );

  function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    v0  = p[63:32];
    v1  = p[31:0];
    sum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + 32'h9E3779B9;
      v0  = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
      v1  = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  // Core model: acts 2 time units after each rising edge, after the
  // stimulus settles. Cipher is computed from the operands the DUT
  // presents at done time, so operand drift shows up as a bad cipher.
  always @(posedge clk) begin
    #2;
    if (!core_reset_n) begin
      cdown     = 0;
      clr       = 0;
      core_done = 1'b0;
    end else begin
      if (!level_mode) core_done = 1'b0;
      if (clr > 0) begin
        clr = clr - 1;
        if (clr == 0) core_done = 1'b0;
      end
      if (cdown > 0) begin
        cdown = cdown - 1;
        if (cdown == 0) begin
          core_done   = 1'b1;
          core_cipher = tea_enc(core_plain, core_key);
        end
      end
      if (core_start) begin
        cdown = lat;
        if (level_mode) clr = 2;
      end
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [63:0] p, input logic [127:0] k);
    req_valid[r]         = v;
    req_plain[r*64 +: 64]   = p;
    req_key[r*128 +: 128]   = k;
  endtask

  // Waits (bounded) for any req_ready; returns sampled value at that negedge.
  task automatic wait_ready(output logic [1:0] rr);
    rr = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rr = req_ready;
      if (rr != 2'b00) break;
    end
  endtask

  // Counts negedges until rsp_valid (bounded). k = cycles waited.
  task automatic wait_rsp(output int k, output int rlow, output bit rr_bad);
    k = 0; rlow = 0; rr_bad = 1'b0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (!core_reset_n)      rlow++;
      if (req_ready != 2'b00) rr_bad = 1'b1;
      if (rsp_valid) break;
    end
  endtask

  typedef struct {
    int           req;
    logic [63:0]  plain;
    logic [127:0] key;
    int           lat;
    int           exp_lat;   // cycles from core_start to rsp_valid
    logic         exp_err;
    int           exp_rlow;  // cycles of core_reset_n low
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    logic [1:0] rr;
    int k, rlow;
    bit rr_bad;
    set_req(v.req, 1'b1, v.plain, v.key);
    lat = v.lat;
    wait_ready(rr);
    check("grant", 128'(rr), 128'(2'b01 << v.req));
    @(posedge clk); #1;
    // requester is free to change data after the handshake
    set_req(v.req, 1'b0, ~v.plain, ~v.key);
    @(negedge clk);
    check("core_start_after_accept", 128'(core_start), 128'(1));
    check("core_plain", 128'(core_plain), 128'(v.plain));
    check("core_key", core_key, v.key);
    wait_rsp(k, rlow, rr_bad);
    check("rsp_latency", 128'(k), 128'(v.exp_lat));
    check("core_reset_n_low_cycles", 128'(rlow), 128'(v.exp_rlow));
    check("req_ready_quiet_in_job", 128'(rr_bad), 128'(0));
    check("rsp_id", 128'(rsp_id), 128'(v.req));
    check("rsp_err", 128'(rsp_err), 128'(v.exp_err));
    check("rsp_cipher", 128'(rsp_cipher),
          128'(v.exp_err ? 64'd0 : tea_enc(v.plain, v.key)));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   rr;
    logic [63:0]  p0, p1, c_cip;
    logic [127:0] k0, k1;
    logic [0:0]   c_id;
    logic         c_err;
    int  k, rlow, expg;
    bit  rr_bad, stable;

    p0 = 64'h0123456789ABCDEF;  k0 = 128'h00112233445566778899AABBCCDDEEFF;
    p1 = 64'hFEDCBA9876543210;  k1 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    //           req plain                  key                                     lat  exp_lat err rlow
    vecs[0] = '{0, 64'h0123456789ABCDEF, 128'h00112233445566778899AABBCCDDEEFF, 33, 34, 1'b0, 0};
    vecs[1] = '{1, 64'hDEADBEEFCAFEF00D, 128'h0123456789ABCDEFFEDCBA9876543210,  2,  3, 1'b0, 0};
    vecs[2] = '{0, 64'h0000000000000001, 128'h00000000000000000000000000000000, 62, 63, 1'b0, 0};
    vecs[3] = '{1, 64'hA5A5A5A55A5A5A5A, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 64, 65, 1'b0, 0};
    vecs[4] = '{0, 64'h1111111122222222, 128'h33333333444444445555555566666666, 65, 66, 1'b1, 1};
    vecs[5] = '{1, 64'h7777777788888888, 128'h99999999AAAAAAAABBBBBBBBCCCCCCCC,  0, 66, 1'b1, 1};
    vecs[6] = '{0, 64'hCAFEBABE00C0FFEE, 128'h1234567890ABCDEF1234567890ABCDEF,  5,  6, 1'b0, 0};

    reset       = 1'b1;
    req_valid   = '0;
    req_plain   = '0;
    req_key     = '0;
    rsp_ready   = 1'b1;
    core_done   = 1'b0;
    core_cipher = 64'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("core_reset_n_in_reset", 128'(core_reset_n), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset_payload", {rsp_cipher, 62'd0, rsp_id, rsp_err}, 128'd0);
    check("reset_core_start", 128'(core_start), 128'(0));
    check("reset_core_reset_n", 128'(core_reset_n), 128'(1));
    check("reset_core_ops", {core_plain, 64'd0} ^ {64'd0, core_key[63:0]} ^ {core_key[127:64], 64'd0}, 128'd0);
    check("reset_req_ready", 128'(req_ready), 128'(0));
    @(posedge clk); #1;

    // ---- table-driven single jobs (incl. done/timeout tie and timeouts)
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // ---- contention: last served was 0, so 1 goes first
    lat = 3;
    set_req(0, 1'b1, p0, k0);
    set_req(1, 1'b1, p1, k1);
    expg = 1;
    for (int j = 0; j < 8; j++) begin
      wait_ready(rr);
      check("contention_grant", 128'(rr), 128'(2'b01 << expg));
      @(posedge clk); #1;
      if (j == 7) req_valid = 2'b00;
      wait_rsp(k, rlow, rr_bad);
      check("contention_req_ready_quiet", 128'(rr_bad), 128'(0));
      check("contention_rsp_id", 128'(rsp_id), 128'(expg));
      check("contention_cipher", 128'(rsp_cipher), 128'(tea_enc(expg ? p1 : p0, expg ? k1 : k0)));
      @(posedge clk); #1;
      if (j == 7) req_valid = 2'b00;
      expg ^= 1;
    end

    // ---- back-pressure
    rsp_ready = 1'b0;
    set_req(1, 1'b1, p1, k1);
    wait_ready(rr);
    check("bp_grant", 128'(rr), 128'(2'b10));
    @(posedge clk); #1;
    set_req(1, 1'b0, 64'd0, 128'd0);
    set_req(0, 1'b1, p0, k0);
    wait_rsp(k, rlow, rr_bad);
    c_id = rsp_id; c_cip = rsp_cipher; c_err = rsp_err;
    check("bp_rsp_id", 128'(c_id), 128'(1));
    check("bp_rsp_cipher", 128'(c_cip), 128'(tea_enc(p1, k1)));
    stable = 1'b1; rr_bad = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_id == c_id && rsp_cipher == c_cip && rsp_err == c_err)) stable = 1'b0;
      if (req_ready != 2'b00) rr_bad = 1'b1;
    end
    check("bp_payload_stable", 128'(stable), 128'(1));
    check("bp_req_ready_quiet", 128'(rr_bad), 128'(0));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rsp_valid_at_handshake", 128'(rsp_valid), 128'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_next_accept", 128'(req_ready), 128'(2'b01));
    @(posedge clk); #1;
    set_req(0, 1'b0, 64'd0, 128'd0);
    wait_rsp(k, rlow, rr_bad);
    check("bp_next_rsp_id", 128'(rsp_id), 128'(0));
    check("bp_next_cipher", 128'(rsp_cipher), 128'(tea_enc(p0, k0)));
    @(posedge clk); #1;

    // ---- stale level-done: done stays high into the next LAUNCH
    level_mode = 1'b1;
    run_vec('{1, 64'h0BADF00D0BADF00D, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 4, 5, 1'b0, 0});
    run_vec('{0, 64'h5555AAAA5555AAAA, 128'h0102030405060708090A0B0C0D0E0F10, 33, 34, 1'b0, 0});
    level_mode = 1'b0;

    // ---- reset mid-BUSY (last served is 0, so only reset makes 0 win)
    lat = 33;
    set_req(1, 1'b1, p1, k1);
    wait_ready(rr);
    @(posedge clk); #1;
    set_req(1, 1'b0, 64'd0, 128'd0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_busy_payload", {rsp_cipher, 62'd0, rsp_id, rsp_err}, 128'd0);
    check("rst_busy_core_start", 128'(core_start), 128'(0));
    check("rst_busy_core_reset_n", 128'(core_reset_n), 128'(1));
    check("rst_busy_core_plain", 128'(core_plain), 128'd0);
    check("rst_busy_core_key", core_key, 128'd0);
    stable = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (rsp_valid) stable = 1'b0;
    end
    check("rst_busy_no_response", 128'(stable), 128'(1));
    @(posedge clk); #1;
    set_req(0, 1'b1, p0, k0);
    set_req(1, 1'b1, p1, k1);
    @(negedge clk);
    check("rst_busy_first_grant", 128'(req_ready), 128'(2'b01));
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(k, rlow, rr_bad);
    check("rst_busy_rsp_id", 128'(rsp_id), 128'(0));
    check("rst_busy_rsp_cipher", 128'(rsp_cipher), 128'(tea_enc(p0, k0)));
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_tea_job_scheduler
`default_nettype wire
